// File: rtl/hazard_pkg.sv
// Shared types for the F/D/E/M/W hazard/forwarding controller:
// operand-forward select encoding, the per-stage tracking record and the
// register-match helper used by every hazard check.
package hazard_pkg;

  // Default register-address width (32 GPRs). The tracking record is sized
  // by this value, so a wider register file needs this constant widened too.
  localparam int RA_W_DEF = 5;

  typedef logic [RA_W_DEF-1:0] regAddr_t;

  // Operand source selected in front of the E-stage ALU
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,  // value read from the register file
    FWD_W  = 2'b01,  // ResultW
    FWD_M  = 2'b10   // ALU result held in M
  } fwd_sel_t;

  // What the hazard logic needs to remember about one in-flight instruction.
  // The valid bit is the first (most significant) field so that storage can
  // split it from the payload.
  typedef struct packed {
    logic     v;
    regAddr_t rd;
    logic     regwr;
    logic     load;
    logic     mem;
    regAddr_t rs1;
    regAddr_t rs2;
    logic     use1;
    logic     use2;
  } stage_rec_t;

  localparam int REC_W = $bits(stage_rec_t);

  // True when the recorded instruction will write register r. With a
  // hardwired x0, writes to register 0 never count as a producer.
  function automatic logic recMatch(stage_rec_t s, regAddr_t r, logic zeroHw);
    return s.v && s.regwr && (s.rd == r) && !(zeroHw && (r == '0));
  endfunction

endpackage

// File: rtl/hazard_stage_rec.sv
// One tracking register (E, M or W copy of an instruction's hazard record).
// Only the valid bit is reset; the payload is meaningless while v=0 and is
// zeroed on a flush so that a bubble never selects a forwarding path.
module hazard_stage_rec
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [REC_W-1:0] recIn,
  output logic [REC_W-1:0] recOut
);

  logic             vQ;
  logic [REC_W-2:0] fieldsQ;

  // Valid bit: cleared asynchronously by reset, dropped on a flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vQ <= 1'b0;
    end else if (en) begin
      vQ <= clr ? 1'b0 : recIn[REC_W-1];
    end
  end

  // Payload: follows the previous stage, zeroed when a bubble is inserted
  always_ff @(posedge clk) begin
    if (en) begin
      fieldsQ <= clr ? '0 : recIn[REC_W-2:0];
    end
  end

  assign recOut = {vQ, fieldsQ};

endmodule

// File: rtl/hazard_unit.sv
// Hazard/forwarding controller for the 5-stage F/D/E/M/W datapath.
// Keeps E/M/W tracking records of in-flight destinations and derives,
// combinationally and with no added latency, operand forwarding selects,
// load-use stalls, taken-branch flushes and data-memory freezes, plus
// saturating stall and flush event counters.
// Priority: memory stall > taken-branch flush > load-use bubble.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int RA_W    = RA_W_DEF,
  parameter bit ZERO_HW = 1'b1,
  parameter bit RF_BYP  = 1'b0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [RA_W-1:0]  d_rs1,
  input  logic [RA_W-1:0]  d_rs2,
  input  logic             d_use1,
  input  logic             d_use2,
  input  logic [RA_W-1:0]  d_rd,
  input  logic             d_regwr,
  input  logic             d_load,
  input  logic             d_mem,
  input  logic             br_taken_m,
  input  logic             mem_ready,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_m,
  output logic             flush_w,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             fwd_a_d,
  output logic             fwd_b_d,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] satInc(logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // M result wins over W result; otherwise read the register file
  function automatic fwd_sel_t fwdPick(logic fromM, logic fromW);
    if (fromM) return FWD_M;
    if (fromW) return FWD_W;
    return FWD_RF;
  endfunction

  stage_rec_t       recD;
  stage_rec_t       recE;
  stage_rec_t       recM;
  stage_rec_t       recW;
  logic [REC_W-1:0] recEVec;
  logic [REC_W-1:0] recMVec;
  logic [REC_W-1:0] recWVec;

  logic memStall;
  logic brFlush;
  logic loadUse;
  logic useHitE;
  logic unusedRecBits;

  // Build the record image of the instruction currently in D
  always_comb begin
    recD       = '0;
    recD.v     = d_valid;
    recD.rd    = regAddr_t'(d_rd);
    recD.regwr = d_regwr;
    recD.load  = d_load;
    recD.mem   = d_mem;
    recD.rs1   = regAddr_t'(d_rs1);
    recD.rs2   = regAddr_t'(d_rs2);
    recD.use1  = d_use1;
    recD.use2  = d_use2;
  end

  // E and M freeze while memory stalls; a flush turns them into bubbles.
  // W always advances, but takes a bubble during a memory stall so the
  // held M instruction is not written back twice.
  hazard_stage_rec uRecE (
    .clk    (clk),
    .reset  (reset),
    .en     (~memStall),
    .clr    (flush_e),
    .recIn  (recD),
    .recOut (recEVec)
  );

  hazard_stage_rec uRecM (
    .clk    (clk),
    .reset  (reset),
    .en     (~memStall),
    .clr    (flush_m),
    .recIn  (recE),
    .recOut (recMVec)
  );

  hazard_stage_rec uRecW (
    .clk    (clk),
    .reset  (reset),
    .en     (1'b1),
    .clr    (memStall),
    .recIn  (recM),
    .recOut (recWVec)
  );

  assign recE = stage_rec_t'(recEVec);
  assign recM = stage_rec_t'(recMVec);
  assign recW = stage_rec_t'(recWVec);

  // Every record field is kept for debug visibility even where no check reads it
  assign unusedRecBits = ^{recEVec, recMVec, recWVec};

  // Classify this cycle's hazard; higher-priority events mask lower ones
  always_comb begin
    memStall = recM.v & recM.mem & ~mem_ready;
    brFlush  = br_taken_m & recM.v & ~memStall;
    useHitE  = (recMatch(recE, recD.rs1, ZERO_HW) & d_use1) |
               (recMatch(recE, recD.rs2, ZERO_HW) & d_use2);
    loadUse  = d_valid & recE.v & recE.load & useHitE & ~memStall & ~brFlush;
  end

  // Stall/flush controls for the pipeline registers
  always_comb begin
    stall_f = memStall | loadUse;
    stall_d = memStall | loadUse;
    stall_e = memStall;
    stall_m = memStall;
    flush_d = brFlush;
    flush_e = brFlush | loadUse;
    flush_m = brFlush;
    flush_w = memStall;
  end

  // Operand forwarding: E operands from M or W, D operands from W
  always_comb begin
    fwd_a_e = fwdPick(recMatch(recM, recE.rs1, ZERO_HW) & recE.use1,
                      recMatch(recW, recE.rs1, ZERO_HW));
    fwd_b_e = fwdPick(recMatch(recM, recE.rs2, ZERO_HW) & recE.use2,
                      recMatch(recW, recE.rs2, ZERO_HW));
    fwd_a_d = 1'b0;
    fwd_b_d = 1'b0;
    if (!RF_BYP) begin
      fwd_a_d = recMatch(recW, recD.rs1, ZERO_HW) & d_use1;
      fwd_b_d = recMatch(recW, recD.rs2, ZERO_HW) & d_use2;
    end
  end

  // Saturating event counters: cycles spent stalling F, taken-branch flushes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_f) stall_cnt <= satInc(stall_cnt);
      if (brFlush) flush_cnt <= satInc(flush_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit. Each table row is one clock cycle:
// D-stage inputs, branch/memory handshakes, and the hand-derived outputs
// expected in that cycle. The driver applies a row and queues its
// expectation; an independent monitor pops and checks on the falling edge.
module tb_hazard_unit;

  localparam int RA_W  = 5;
  localparam int CNT_W = 3;   // small so saturation is reachable quickly

  typedef struct packed {
    logic       dv;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    logic       mem;
  } insn_t;

  typedef struct {
    logic             rstn;
    insn_t            in;
    logic             br;
    logic             rdy;
    logic [7:0]       ctl;   // {stall_f,stall_d,stall_e,stall_m,flush_d,flush_e,flush_m,flush_w}
    logic [5:0]       fwd;   // {fwd_a_e,fwd_b_e,fwd_a_d,fwd_b_d}
    logic [CNT_W-1:0] scnt;
    logic [CNT_W-1:0] fcnt;
  } row_t;

  typedef struct {
    int               idx;
    logic [7:0]       ctl;
    logic [5:0]       fwd;
    logic [CNT_W-1:0] scnt;
    logic [CNT_W-1:0] fcnt;
  } exp_t;

  localparam logic [7:0] C_NONE = 8'b0000_0000;
  localparam logic [7:0] C_LU   = 8'b1100_0100;
  localparam logic [7:0] C_BR   = 8'b0000_1110;
  localparam logic [7:0] C_MEM  = 8'b1111_0001;

  logic             clk;
  logic             reset;
  logic             d_valid;
  logic [RA_W-1:0]  d_rs1;
  logic [RA_W-1:0]  d_rs2;
  logic             d_use1;
  logic             d_use2;
  logic [RA_W-1:0]  d_rd;
  logic             d_regwr;
  logic             d_load;
  logic             d_mem;
  logic             br_taken_m;
  logic             mem_ready;
  logic             stall_f;
  logic             stall_d;
  logic             stall_e;
  logic             stall_m;
  logic             flush_d;
  logic             flush_e;
  logic             flush_m;
  logic             flush_w;
  logic [1:0]       fwd_a_e;
  logic [1:0]       fwd_b_e;
  logic             fwd_a_d;
  logic             fwd_b_d;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  row_t rows[$];
  exp_t expQ[$];
  exp_t mon;
  int   nChecks = 0;
  int   nFails  = 0;

  hazard_unit #(
    .RA_W    (RA_W),
    .ZERO_HW (1'b1),
    .RF_BYP  (1'b0),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .d_valid    (d_valid),
    .d_rs1      (d_rs1),
    .d_rs2      (d_rs2),
    .d_use1     (d_use1),
    .d_use2     (d_use2),
    .d_rd       (d_rd),
    .d_regwr    (d_regwr),
    .d_load     (d_load),
    .d_mem      (d_mem),
    .br_taken_m (br_taken_m),
    .mem_ready  (mem_ready),
    .stall_f    (stall_f),
    .stall_d    (stall_d),
    .stall_e    (stall_e),
    .stall_m    (stall_m),
    .flush_d    (flush_d),
    .flush_e    (flush_e),
    .flush_m    (flush_m),
    .flush_w    (flush_w),
    .fwd_a_e    (fwd_a_e),
    .fwd_b_e    (fwd_b_e),
    .fwd_a_d    (fwd_a_d),
    .fwd_b_d    (fwd_b_d),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic insn_t opNop();
    return '0;
  endfunction

  function automatic insn_t opAdd(int rd, int rs1, int rs2);
    insn_t i = '0;
    i.dv = 1'b1; i.rd = rd[4:0]; i.rs1 = rs1[4:0]; i.rs2 = rs2[4:0];
    i.u1 = 1'b1; i.u2 = 1'b1; i.rw = 1'b1;
    return i;
  endfunction

  function automatic insn_t opAddi(int rd, int rs1);
    insn_t i = '0;
    i.dv = 1'b1; i.rd = rd[4:0]; i.rs1 = rs1[4:0]; i.u1 = 1'b1; i.rw = 1'b1;
    return i;
  endfunction

  function automatic insn_t opLw(int rd, int rs1);
    insn_t i = opAddi(rd, rs1);
    i.ld = 1'b1; i.mem = 1'b1;
    return i;
  endfunction

  function automatic insn_t opSw(int rs1, int rs2);
    insn_t i = '0;
    i.dv = 1'b1; i.rs1 = rs1[4:0]; i.rs2 = rs2[4:0];
    i.u1 = 1'b1; i.u2 = 1'b1; i.mem = 1'b1;
    return i;
  endfunction

  task automatic addRow(input logic rstn, input insn_t in, input logic br, input logic rdy,
                        input logic [7:0] ctl, input logic [1:0] fae, input logic [1:0] fbe,
                        input logic fad, input logic fbd, input int scnt, input int fcnt);
    row_t r;
    r.rstn = rstn; r.in = in; r.br = br; r.rdy = rdy; r.ctl = ctl;
    r.fwd  = {fae, fbe, fad, fbd};
    r.scnt = scnt[CNT_W-1:0];
    r.fcnt = fcnt[CNT_W-1:0];
    rows.push_back(r);
  endtask

  task automatic buildRows();
    // reset held: everything zero regardless of D inputs
    addRow(0, opAdd(5, 1, 2), 0, 1, C_NONE, 2'b00, 2'b00, 0, 0, 0, 0);  // 0
    addRow(0, opLw(7, 2),     0, 1, C_NONE, 2'b00, 2'b00, 0, 0, 0, 0);  // 1
    // back-to-back dependency: forward from M
    addRow(1, opAdd(5, 1, 2), 0, 1, C_NONE, 2'b00, 2'b00, 0, 0, 0, 0);  // 2
    addRow(1, opAdd(6, 5, 1), 0, 1, C_NONE, 2'b00, 2'b00, 0, 0, 0, 0);  // 3
    addRow(1, opNop(),        0, 1, C_NONE, 2'b10, 2'b00, 0, 0, 0, 0);  // 4
    addRow(1, opNop(),        0, 1, C_NONE, 2'b00, 2'b00, 0, 0, 0, 0);  // 5
    // one unrelated instruction between: forward from W, plus D bypass
    addRow(1, opAdd(5, 1, 2), 0, 1, C_NONE, 2'b00, 2'b00, 0, 0, 0, 0);  // 6
    addRow(1, opAdd(9, 3, 4), 0, 1, C_NONE, 2'b00, 2'b00, 0, 0, 0, 0);  // 7
    addRow(1, opAdd(6, 5, 1), 0, 1, C_NONE, 2'b00, 2'b00, 0, 0, 0, 0);  // 8
    addRow(1, opAdd(7, 5, 5), 0, 1, C_NONE, 2'b01, 2'b00, 1, 1, 0, 0);  // 9
    addRow(1, opNop(),        0, 1, C_NONE, 2'b00, 2'b00, 0, 0, 0, 0);  // 10
    addRow(1, opNop(),        0, 1, C_NONE, 2'b00, 2'b00, 0, 0, 0, 0);  // 11
    // load-use: one bubble, then forward from W
    addRow(1, opLw(7, 2),     0, 1, C_NONE, 2'b00, 2'b00, 0, 0, 0, 0);  // 12
    addRow(1, opAdd(8, 7, 3), 0, 1, C_LU,   2'b00, 2'b00, 0, 0, 0, 0);  // 13
    addRow(1, opAdd(8, 7, 3), 0, 1, C_NONE, 2'b00, 2'b00, 0, 0, 1, 0);  // 14
    addRow(1, opNop(),        0, 1, C_NONE, 2'b01, 2'b00, 0, 0, 1, 0);  // 15
    // x0 producer (a load) and x0 reader: no stall, no forward
    addRow(1, opLw(0, 1),     0, 1, C_NONE, 2'b00, 2'b00, 0, 0, 1, 0);  // 16
    addRow(1, opAdd(3, 0, 0), 0, 1, C_NONE, 2'b00, 2'b00, 0, 0, 1, 0);  // 17
    addRow(1, opNop(),        0, 1, C_NONE, 2'b00, 2'b00, 0, 0, 1, 0);  // 18
    // taken branch in M overrides a simultaneous load-use
    addRow(1, opAdd(10, 1, 2),0, 1, C_NONE, 2'b00, 2'b00, 0, 0, 1, 0);  // 19
    addRow(1, opLw(7, 2),     0, 1, C_NONE, 2'b00, 2'b00, 0, 0, 1, 0);  // 20
    addRow(1, opAdd(8, 7, 3), 1, 1, C_BR,   2'b00, 2'b00, 0, 0, 1, 0);  // 21
    addRow(1, opNop(),        0, 1, C_NONE, 2'b00, 2'b00, 0, 0, 1, 1);  // 22
    // store in M with memory not ready for 3 cycles; W writer gets squashed
    addRow(1, opAdd(20, 1, 2),0, 1, C_NONE, 2'b00, 2'b00, 0, 0, 1, 1);  // 23
    addRow(1, opSw(2, 5),     0, 1, C_NONE, 2'b00, 2'b00, 0, 0, 1, 1);  // 24
    addRow(1, opAdd(11,20,20),0, 1, C_NONE, 2'b00, 2'b00, 0, 0, 1, 1);  // 25
    addRow(1, opAdd(14, 11, 1),0,0, C_MEM,  2'b01, 2'b01, 0, 0, 1, 1);  // 26
    addRow(1, opAdd(14, 11, 1),0,0, C_MEM,  2'b00, 2'b00, 0, 0, 2, 1);  // 27
    addRow(1, opAdd(14, 11, 1),0,0, C_MEM,  2'b00, 2'b00, 0, 0, 3, 1);  // 28
    addRow(1, opAdd(14, 11, 1),0,1, C_NONE, 2'b00, 2'b00, 0, 0, 4, 1);  // 29
    addRow(1, opNop(),        0, 1, C_NONE, 2'b10, 2'b00, 0, 0, 4, 1);  // 30
    // long memory stall: counter saturates at 7, then reset mid-stall
    addRow(1, opSw(2, 5),     0, 1, C_NONE, 2'b00, 2'b00, 0, 0, 4, 1);  // 31
    addRow(1, opNop(),        0, 1, C_NONE, 2'b00, 2'b00, 0, 0, 4, 1);  // 32
    addRow(1, opNop(),        0, 0, C_MEM,  2'b00, 2'b00, 0, 0, 4, 1);  // 33
    addRow(1, opNop(),        0, 0, C_MEM,  2'b00, 2'b00, 0, 0, 5, 1);  // 34
    addRow(1, opNop(),        0, 0, C_MEM,  2'b00, 2'b00, 0, 0, 6, 1);  // 35
    addRow(1, opNop(),        0, 0, C_MEM,  2'b00, 2'b00, 0, 0, 7, 1);  // 36
    addRow(1, opNop(),        0, 0, C_MEM,  2'b00, 2'b00, 0, 0, 7, 1);  // 37
    addRow(1, opNop(),        0, 0, C_MEM,  2'b00, 2'b00, 0, 0, 7, 1);  // 38
    addRow(0, opNop(),        0, 0, C_NONE, 2'b00, 2'b00, 0, 0, 0, 0);  // 39
    // M has priority over W when both hold the same destination
    addRow(1, opAdd(5, 1, 2), 0, 1, C_NONE, 2'b00, 2'b00, 0, 0, 0, 0);  // 40
    addRow(1, opAddi(5, 5),   0, 1, C_NONE, 2'b00, 2'b00, 0, 0, 0, 0);  // 41
    addRow(1, opAdd(6, 5, 5), 0, 1, C_NONE, 2'b10, 2'b00, 0, 0, 0, 0);  // 42
    addRow(1, opNop(),        0, 1, C_NONE, 2'b10, 2'b10, 0, 0, 0, 0);  // 43
    addRow(1, opAdd(1, 6, 5), 0, 1, C_NONE, 2'b00, 2'b00, 0, 1, 0, 0);  // 44
    addRow(1, opNop(),        0, 1, C_NONE, 2'b01, 2'b00, 0, 0, 0, 0);  // 45
  endtask

  task automatic applyRow(input row_t r);
    reset      = r.rstn;
    d_valid    = r.in.dv;
    d_rs1      = r.in.rs1;
    d_rs2      = r.in.rs2;
    d_use1     = r.in.u1;
    d_use2     = r.in.u2;
    d_rd       = r.in.rd;
    d_regwr    = r.in.rw;
    d_load     = r.in.ld;
    d_mem      = r.in.mem;
    br_taken_m = r.br;
    mem_ready  = r.rdy;
  endtask

  // Driver: one row per cycle, applied just after the rising edge
  initial begin
    row_t idle;
    idle.rstn = 1'b0; idle.in = '0; idle.br = 1'b0; idle.rdy = 1'b1;
    idle.ctl = '0; idle.fwd = '0; idle.scnt = '0; idle.fcnt = '0;
    applyRow(idle);
    buildRows();
    foreach (rows[i]) begin
      exp_t e;
      @(posedge clk);
      #1;
      applyRow(rows[i]);
      e.idx = i; e.ctl = rows[i].ctl; e.fwd = rows[i].fwd;
      e.scnt = rows[i].scnt; e.fcnt = rows[i].fcnt;
      expQ.push_back(e);
    end
    @(posedge clk);
    @(posedge clk);
    nChecks++;
    if (expQ.size() != 0) begin
      nFails++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  // Monitor: compare the DUT outputs on the falling edge against the queue
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      mon = expQ.pop_front();
      nChecks++;
      if ({stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w} !== mon.ctl) begin
        nFails++;
        $display("FAIL row%0d ctl: got %b required %b", mon.idx,
                 {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w}, mon.ctl);
      end
      nChecks++;
      if ({fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d} !== mon.fwd) begin
        nFails++;
        $display("FAIL row%0d fwd: got %b required %b", mon.idx,
                 {fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d}, mon.fwd);
      end
      nChecks++;
      if (stall_cnt !== mon.scnt || flush_cnt !== mon.fcnt) begin
        nFails++;
        $display("FAIL row%0d cnt: got stall=%0d flush=%0d required stall=%0d flush=%0d",
                 mon.idx, stall_cnt, flush_cnt, mon.scnt, mon.fcnt);
      end
    end
  end

  // Guard against a run that never completes
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d rows pending", expQ.size());
    $fatal(1, "watchdog");
  end

endmodule
